ysyx_23060072_fwd_hazard_unit: RTL and testbench

//  Parametrised forwarding and hazard unit for the 5-stage rv32e pipeline, sitting beside the EX stage.

---
 rtl/ysyx_23060072_fwd_hazard_unit_pkg.sv | 17 +
 rtl/ysyx_23060072_fwd_mux.sv | 55 +++++
 rtl/ysyx_23060072_fwd_hazard_unit.sv | 134 +++++++++++++
 tb/tb_ysyx_23060072_fwd_hazard_unit.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060072_fwd_hazard_unit_pkg.sv
// Shared encodings for the EX-side forwarding / load-use hazard unit.
package ysyx_23060072_fwd_hazard_unit_pkg;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_LDWAIT = 1'b1
  } lu_state_e;

  typedef enum logic [2:0] {
    FWD_MEM  = 3'd0,
    FWD_LD   = 3'd1,
    FWD_HOLD = 3'd2,
    FWD_WB   = 3'd3,
    FWD_ID   = 3'd4
  } fwd_sel_e;

endpackage

// File: rtl/ysyx_23060072_fwd_mux.sv
// Single-source operand priority mux; also flags a pending load on this source.
module ysyx_23060072_fwd_mux
  import ysyx_23060072_fwd_hazard_unit_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 4
) (
  input  logic              has_rs,
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [XLEN-1:0]   rs_data,
  input  logic              mem_valid,
  input  logic              mem_wb_en,
  input  logic              mem_is_load,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [XLEN-1:0]   mem_ex_result,
  input  logic              mem_load_done,
  input  logic [XLEN-1:0]   mem_load_data,
  input  logic              hold_vld,
  input  logic [XLEN-1:0]   hold,
  input  logic              wb_valid,
  input  logic              wb_wb_en,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic [XLEN-1:0]   opnd,
  output fwd_sel_e          sel,
  output logic              ld_pend
);

  logic mem_hit;
  logic wb_hit;

  // x0 is hard-wired, so a write to it must never be forwarded
  assign mem_hit = has_rs & mem_valid & mem_wb_en & (mem_rd != '0) & (mem_rd == rs_addr);
  assign wb_hit  = has_rs & wb_valid & wb_wb_en & (wb_rd != '0) & (wb_rd == rs_addr);
  assign ld_pend = mem_hit & mem_is_load & ~mem_load_done;

  always_comb begin
    sel  = FWD_ID;
    opnd = rs_data;
    if (mem_hit && !mem_is_load) begin
      sel  = FWD_MEM;
      opnd = mem_ex_result;
    end else if (mem_hit && mem_load_done) begin
      sel  = FWD_LD;
      opnd = mem_load_data;
    end else if (hold_vld) begin
      sel  = FWD_HOLD;
      opnd = hold;
    end else if (wb_hit) begin
      sel  = FWD_WB;
      opnd = wb_data;
    end
  end

endmodule

// File: rtl/ysyx_23060072_fwd_hazard_unit.sv
// EX-stage forwarding and load-use hazard unit: N-source bypass, load-wait FSM,
// per-source hold registers, WB->MEM store-data bypass and a stall counter.
module ysyx_23060072_fwd_hazard_unit
  import ysyx_23060072_fwd_hazard_unit_pkg::*;
#(
  parameter  int unsigned XLEN   = 32,
  parameter  int unsigned NREG   = 16,
  parameter  int unsigned NSRC   = 2,
  localparam int unsigned REG_AW = $clog2(NREG)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   ex_valid,
  input  logic                   ex_is_store,
  input  logic [NSRC-1:0]        ex_has_rs,
  input  logic [NSRC*REG_AW-1:0] ex_rs_addr,
  input  logic [NSRC*XLEN-1:0]   ex_rs_data,
  input  logic                   mem_valid,
  input  logic                   mem_wb_en,
  input  logic                   mem_is_load,
  input  logic                   mem_is_store,
  input  logic [REG_AW-1:0]      mem_rd,
  input  logic [REG_AW-1:0]      mem_rs1,
  input  logic [REG_AW-1:0]      mem_rs2,
  input  logic [XLEN-1:0]        mem_ex_result,
  input  logic [XLEN-1:0]        mem_store_data,
  input  logic                   mem_load_done,
  input  logic [XLEN-1:0]        mem_load_data,
  input  logic                   wb_valid,
  input  logic                   wb_wb_en,
  input  logic                   wb_is_load,
  input  logic [REG_AW-1:0]      wb_rd,
  input  logic [XLEN-1:0]        wb_data,
  output logic [NSRC*XLEN-1:0]   ex_opnd,
  output logic [XLEN-1:0]        mem_store_data_o,
  output logic                   ex_stall,
  output logic [XLEN-1:0]        lu_stall_cnt
);

  lu_state_e         state_q;
  lu_state_e         state_d;
  logic [NSRC-1:0]   hold_vld_q;
  logic [XLEN-1:0]   hold_q [NSRC];
  logic [XLEN-1:0]   opnd_w [NSRC];
  fwd_sel_e          sel_w  [NSRC];
  logic [NSRC-1:0]   ld_pend;
  logic [NSRC-1:0]   haz;
  logic              hold_clr;
  logic              cnt_inc;

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    ysyx_23060072_fwd_mux #(
      .XLEN   (XLEN),
      .REG_AW (REG_AW)
    ) u_mux (
      .has_rs        (ex_has_rs[i]),
      .rs_addr       (ex_rs_addr[i*REG_AW +: REG_AW]),
      .rs_data       (ex_rs_data[i*XLEN +: XLEN]),
      .mem_valid     (mem_valid),
      .mem_wb_en     (mem_wb_en),
      .mem_is_load   (mem_is_load),
      .mem_rd        (mem_rd),
      .mem_ex_result (mem_ex_result),
      .mem_load_done (mem_load_done),
      .mem_load_data (mem_load_data),
      .hold_vld      (hold_vld_q[i]),
      .hold          (hold_q[i]),
      .wb_valid      (wb_valid),
      .wb_wb_en      (wb_wb_en),
      .wb_rd         (wb_rd),
      .wb_data       (wb_data),
      .opnd          (opnd_w[i]),
      .sel           (sel_w[i]),
      .ld_pend       (ld_pend[i])
    );

    assign ex_opnd[i*XLEN +: XLEN] = opnd_w[i];

    // Store data is only needed in MEM, where the WB->MEM bypass covers it
    if (i == 1) begin : g_sdata
      assign haz[i] = ld_pend[i] & ~ex_is_store;
    end else begin : g_opnd
      assign haz[i] = ld_pend[i];
    end
  end

  assign ex_stall = ex_valid & (|haz) & ~flush;

  assign mem_store_data_o =
    (wb_is_load & wb_wb_en & mem_is_store & (wb_rd != '0) &
     (wb_rd == mem_rs2) & (wb_rd != mem_rs1)) ? wb_data : mem_store_data;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:    if (ex_stall) state_d = ST_LDWAIT;
      ST_LDWAIT: if (flush || !ex_stall) state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase
  end

  // Hold is only ever valid in LDWAIT, so leaving LDWAIT is the release point
  always_comb begin
    hold_clr = 1'b0;
    cnt_inc  = ex_stall;
    if (state_q == ST_LDWAIT && !ex_stall) hold_clr = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst || hold_clr) begin
      hold_vld_q <= '0;
      for (int unsigned i = 0; i < NSRC; i++) hold_q[i] <= '0;
    end else if (ex_stall) begin
      for (int unsigned i = 0; i < NSRC; i++) begin
        if (sel_w[i] == FWD_LD || sel_w[i] == FWD_WB) begin
          hold_q[i]     <= opnd_w[i];
          hold_vld_q[i] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                               lu_stall_cnt <= '0;
    else if (cnt_inc && lu_stall_cnt != '1) lu_stall_cnt <= lu_stall_cnt + XLEN'(1);
  end

endmodule

// File: tb/tb_ysyx_23060072_fwd_hazard_unit.sv
// Scenario bench for the forwarding / hazard unit with a per-cycle expectation queue.
module tb_ysyx_23060072_fwd_hazard_unit;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NSRC = 2;
  localparam int unsigned AW   = 4;

  logic                 clk;
  logic                 rst;
  logic                 flush;
  logic                 ex_valid;
  logic                 ex_is_store;
  logic [NSRC-1:0]      ex_has_rs;
  logic [NSRC*AW-1:0]   ex_rs_addr;
  logic [NSRC*XLEN-1:0] ex_rs_data;
  logic                 mem_valid, mem_wb_en, mem_is_load, mem_is_store;
  logic [AW-1:0]        mem_rd, mem_rs1, mem_rs2;
  logic [XLEN-1:0]      mem_ex_result, mem_store_data, mem_load_data;
  logic                 mem_load_done;
  logic                 wb_valid, wb_wb_en, wb_is_load;
  logic [AW-1:0]        wb_rd;
  logic [XLEN-1:0]      wb_data;
  logic [NSRC*XLEN-1:0] ex_opnd;
  logic [XLEN-1:0]      mem_store_data_o;
  logic                 ex_stall;
  logic [XLEN-1:0]      lu_stall_cnt;

  typedef struct {
    logic [XLEN-1:0] op0;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] sdata;
    logic [XLEN-1:0] cnt;
    logic            stall;
  } exp_t;

  exp_t        sb[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  int unsigned exp_cnt = 0;

  ysyx_23060072_fwd_hazard_unit #(.XLEN(XLEN), .NREG(16), .NSRC(NSRC)) dut (
    .clk (clk), .rst (rst), .flush (flush),
    .ex_valid (ex_valid), .ex_is_store (ex_is_store), .ex_has_rs (ex_has_rs),
    .ex_rs_addr (ex_rs_addr), .ex_rs_data (ex_rs_data),
    .mem_valid (mem_valid), .mem_wb_en (mem_wb_en), .mem_is_load (mem_is_load),
    .mem_is_store (mem_is_store), .mem_rd (mem_rd), .mem_rs1 (mem_rs1), .mem_rs2 (mem_rs2),
    .mem_ex_result (mem_ex_result), .mem_store_data (mem_store_data),
    .mem_load_done (mem_load_done), .mem_load_data (mem_load_data),
    .wb_valid (wb_valid), .wb_wb_en (wb_wb_en), .wb_is_load (wb_is_load),
    .wb_rd (wb_rd), .wb_data (wb_data),
    .ex_opnd (ex_opnd), .mem_store_data_o (mem_store_data_o),
    .ex_stall (ex_stall), .lu_stall_cnt (lu_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic idle_inputs();
    rst = 1'b0; flush = 1'b0;
    ex_valid = 1'b0; ex_is_store = 1'b0; ex_has_rs = '0; ex_rs_addr = '0; ex_rs_data = '0;
    mem_valid = 1'b0; mem_wb_en = 1'b0; mem_is_load = 1'b0; mem_is_store = 1'b0;
    mem_rd = '0; mem_rs1 = '0; mem_rs2 = '0;
    mem_ex_result = '0; mem_store_data = '0; mem_load_done = 1'b0; mem_load_data = '0;
    wb_valid = 1'b0; wb_wb_en = 1'b0; wb_is_load = 1'b0; wb_rd = '0; wb_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic ld_pending(input logic [AW-1:0] rd);
    mem_valid = 1'b1; mem_wb_en = 1'b1; mem_is_load = 1'b1; mem_rd = rd; mem_load_done = 1'b0;
  endtask

  task automatic set_ex(input logic [1:0] has, input logic [AW-1:0] rs2, input logic [AW-1:0] rs1,
                        input logic [XLEN-1:0] d2, input logic [XLEN-1:0] d1);
    ex_valid = 1'b1; ex_has_rs = has; ex_rs_addr = {rs2, rs1}; ex_rs_data = {d2, d1};
  endtask

  task automatic push_exp(input logic [XLEN-1:0] op0, input logic [XLEN-1:0] op1,
                          input logic st, input logic [XLEN-1:0] sd);
    sb.push_back('{op0: op0, op1: op1, sdata: sd, cnt: exp_cnt, stall: st});
    if (st) exp_cnt++;
  endtask

  task automatic test_reset();
    exp_t e;
    idle_inputs();
    rst = 1'b1;
    ex_rs_data = {32'h0000_000B, 32'h0000_000A};
    mem_store_data = 32'h5a5a;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_cnt = 0;
    push_exp(32'hA, 32'hB, 1'b0, 32'h5a5a);
    @(negedge clk);
    e = sb.pop_front(); n_chk++;
    if ({ex_opnd[31:0], ex_opnd[63:32], ex_stall, mem_store_data_o, lu_stall_cnt} !==
        {e.op0, e.op1, e.stall, e.sdata, e.cnt}) begin
      n_fail++;
      $display("FAIL reset: got op0=%h op1=%h stall=%b sd=%h cnt=%0d want op0=%h op1=%h stall=%b sd=%h cnt=%0d",
               ex_opnd[31:0], ex_opnd[63:32], ex_stall, mem_store_data_o, lu_stall_cnt,
               e.op0, e.op1, e.stall, e.sdata, e.cnt);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      idle_inputs();
      case (c)
        0: begin
          mem_valid = 1'b1; mem_wb_en = 1'b1; mem_rd = 4'd5; mem_ex_result = 32'h11;
          set_ex(2'b01, 4'd5, 4'd5, 32'h22, 32'h0);
          push_exp(32'h11, 32'h22, 1'b0, 32'h0);
        end
        1: begin
          mem_valid = 1'b1; mem_wb_en = 1'b1; mem_is_load = 1'b1; mem_rd = 4'd3;
          mem_load_done = 1'b1; mem_load_data = 32'h33;
          wb_valid = 1'b1; wb_wb_en = 1'b1; wb_rd = 4'd3; wb_data = 32'h44;
          set_ex(2'b11, 4'd3, 4'd3, 32'h1, 32'h2);
          push_exp(32'h33, 32'h33, 1'b0, 32'h0);
        end
        default: begin
          wb_valid = 1'b1; wb_wb_en = 1'b1; wb_rd = 4'd4; wb_data = 32'h44;
          set_ex(2'b11, 4'd4, 4'd2, 32'h1, 32'h2);
          push_exp(32'h2, 32'h44, 1'b0, 32'h0);
        end
      endcase
      @(negedge clk);
      e = sb.pop_front(); n_chk++;
      if ({ex_opnd[31:0], ex_opnd[63:32], ex_stall, mem_store_data_o, lu_stall_cnt} !==
          {e.op0, e.op1, e.stall, e.sdata, e.cnt}) begin
        n_fail++;
        $display("FAIL back_to_back c%0d: got op0=%h op1=%h stall=%b sd=%h cnt=%0d want op0=%h op1=%h stall=%b sd=%h cnt=%0d",
                 c, ex_opnd[31:0], ex_opnd[63:32], ex_stall, mem_store_data_o, lu_stall_cnt,
                 e.op0, e.op1, e.stall, e.sdata, e.cnt);
      end
    end
  endtask

  task automatic test_load_use();
    exp_t e;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      idle_inputs();
      ld_pending(4'd6);
      set_ex(2'b10, 4'd6, 4'd0, 32'hdead, 32'h1);
      if (c < 3) begin
        push_exp(32'h1, 32'hdead, 1'b1, 32'h0);
      end else begin
        mem_load_done = 1'b1; mem_load_data = 32'hABCD;
        push_exp(32'h1, 32'hABCD, 1'b0, 32'h0);
      end
      @(negedge clk);
      e = sb.pop_front(); n_chk++;
      if ({ex_opnd[31:0], ex_opnd[63:32], ex_stall, mem_store_data_o, lu_stall_cnt} !==
          {e.op0, e.op1, e.stall, e.sdata, e.cnt}) begin
        n_fail++;
        $display("FAIL load_use c%0d: got op0=%h op1=%h stall=%b sd=%h cnt=%0d want op0=%h op1=%h stall=%b sd=%h cnt=%0d",
                 c, ex_opnd[31:0], ex_opnd[63:32], ex_stall, mem_store_data_o, lu_stall_cnt,
                 e.op0, e.op1, e.stall, e.sdata, e.cnt);
      end
    end
  endtask

  task automatic test_hold();
    exp_t e;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      idle_inputs();
      case (c)
        0: begin
          ld_pending(4'd6);
          set_ex(2'b11, 4'd6, 4'd7, 32'hdead, 32'h0);
          wb_valid = 1'b1; wb_wb_en = 1'b1; wb_rd = 4'd7; wb_data = 32'h77;
          push_exp(32'h77, 32'hdead, 1'b1, 32'h0);
        end
        1: begin
          ld_pending(4'd6);
          set_ex(2'b11, 4'd6, 4'd7, 32'hdead, 32'h0);
          wb_rd = 4'd7; wb_data = 32'h99;
          push_exp(32'h77, 32'hdead, 1'b1, 32'h0);
        end
        2: begin
          ld_pending(4'd6);
          mem_load_done = 1'b1; mem_load_data = 32'h66;
          set_ex(2'b11, 4'd6, 4'd7, 32'hdead, 32'h0);
          push_exp(32'h77, 32'h66, 1'b0, 32'h0);
        end
        default: begin
          set_ex(2'b11, 4'd6, 4'd7, 32'h5, 32'h3);
          push_exp(32'h3, 32'h5, 1'b0, 32'h0);
        end
      endcase
      @(negedge clk);
      e = sb.pop_front(); n_chk++;
      if ({ex_opnd[31:0], ex_opnd[63:32], ex_stall, mem_store_data_o, lu_stall_cnt} !==
          {e.op0, e.op1, e.stall, e.sdata, e.cnt}) begin
        n_fail++;
        $display("FAIL hold c%0d: got op0=%h op1=%h stall=%b sd=%h cnt=%0d want op0=%h op1=%h stall=%b sd=%h cnt=%0d",
                 c, ex_opnd[31:0], ex_opnd[63:32], ex_stall, mem_store_data_o, lu_stall_cnt,
                 e.op0, e.op1, e.stall, e.sdata, e.cnt);
      end
    end
  endtask

  task automatic test_load_store();
    exp_t e;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      idle_inputs();
      case (c)
        0: begin
          ld_pending(4'd8);
          set_ex(2'b11, 4'd8, 4'd9, 32'h1, 32'h900);
          ex_is_store = 1'b1;
          push_exp(32'h900, 32'h1, 1'b0, 32'h0);
        end
        1: begin
          mem_valid = 1'b1; mem_is_store = 1'b1; mem_rs1 = 4'd9; mem_rs2 = 4'd8;
          mem_store_data = 32'h1;
          wb_valid = 1'b1; wb_wb_en = 1'b1; wb_is_load = 1'b1; wb_rd = 4'd8; wb_data = 32'h88;
          push_exp(32'h0, 32'h0, 1'b0, 32'h88);
        end
        2, 3: begin
          ld_pending(4'd8);
          set_ex(2'b11, 4'd1, 4'd8, 32'h10, 32'h20);
          ex_is_store = 1'b1;
          if (c == 2) begin
            push_exp(32'h20, 32'h10, 1'b1, 32'h0);
          end else begin
            mem_load_done = 1'b1; mem_load_data = 32'h1234;
            push_exp(32'h1234, 32'h10, 1'b0, 32'h0);
          end
        end
        4: begin
          mem_valid = 1'b1; mem_is_store = 1'b1; mem_rs1 = 4'd8; mem_rs2 = 4'd8;
          mem_store_data = 32'h5;
          wb_valid = 1'b1; wb_wb_en = 1'b1; wb_is_load = 1'b1; wb_rd = 4'd8; wb_data = 32'h88;
          push_exp(32'h0, 32'h0, 1'b0, 32'h5);
        end
        default: begin
          mem_valid = 1'b1; mem_is_store = 1'b1; mem_rs1 = 4'd3; mem_rs2 = 4'd0;
          mem_store_data = 32'h6;
          wb_valid = 1'b1; wb_wb_en = 1'b1; wb_is_load = 1'b1; wb_rd = 4'd0; wb_data = 32'h88;
          push_exp(32'h0, 32'h0, 1'b0, 32'h6);
        end
      endcase
      @(negedge clk);
      e = sb.pop_front(); n_chk++;
      if ({ex_opnd[31:0], ex_opnd[63:32], ex_stall, mem_store_data_o, lu_stall_cnt} !==
          {e.op0, e.op1, e.stall, e.sdata, e.cnt}) begin
        n_fail++;
        $display("FAIL load_store c%0d: got op0=%h op1=%h stall=%b sd=%h cnt=%0d want op0=%h op1=%h stall=%b sd=%h cnt=%0d",
                 c, ex_opnd[31:0], ex_opnd[63:32], ex_stall, mem_store_data_o, lu_stall_cnt,
                 e.op0, e.op1, e.stall, e.sdata, e.cnt);
      end
    end
  endtask

  task automatic test_x0_flush();
    exp_t e;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      idle_inputs();
      case (c)
        0: begin
          mem_valid = 1'b1; mem_wb_en = 1'b1; mem_rd = 4'd0; mem_ex_result = 32'hbad;
          wb_valid = 1'b1; wb_wb_en = 1'b1; wb_rd = 4'd0; wb_data = 32'hbad2;
          set_ex(2'b11, 4'd0, 4'd0, 32'h1, 32'h2);
          push_exp(32'h2, 32'h1, 1'b0, 32'h0);
        end
        1: begin
          ld_pending(4'd6);
          set_ex(2'b11, 4'd6, 4'd7, 32'hdead, 32'h0);
          wb_valid = 1'b1; wb_wb_en = 1'b1; wb_rd = 4'd7; wb_data = 32'h77;
          push_exp(32'h77, 32'hdead, 1'b1, 32'h0);
        end
        2: begin
          ld_pending(4'd6);
          set_ex(2'b11, 4'd6, 4'd7, 32'hdead, 32'h0);
          flush = 1'b1;
          push_exp(32'h77, 32'hdead, 1'b0, 32'h0);
        end
        3: begin
          set_ex(2'b11, 4'd6, 4'd7, 32'h4, 32'h3);
          push_exp(32'h3, 32'h4, 1'b0, 32'h0);
        end
        default: begin
          ld_pending(4'd6);
          set_ex(2'b11, 4'd6, 4'd7, 32'h4, 32'h3);
          ex_valid = 1'b0;
          push_exp(32'h3, 32'h4, 1'b0, 32'h0);
        end
      endcase
      @(negedge clk);
      e = sb.pop_front(); n_chk++;
      if ({ex_opnd[31:0], ex_opnd[63:32], ex_stall, mem_store_data_o, lu_stall_cnt} !==
          {e.op0, e.op1, e.stall, e.sdata, e.cnt}) begin
        n_fail++;
        $display("FAIL x0_flush c%0d: got op0=%h op1=%h stall=%b sd=%h cnt=%0d want op0=%h op1=%h stall=%b sd=%h cnt=%0d",
                 c, ex_opnd[31:0], ex_opnd[63:32], ex_stall, mem_store_data_o, lu_stall_cnt,
                 e.op0, e.op1, e.stall, e.sdata, e.cnt);
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    exp_t e;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      idle_inputs();
      case (c)
        0: begin
          ld_pending(4'd6);
          set_ex(2'b11, 4'd6, 4'd7, 32'hdead, 32'h0);
          wb_valid = 1'b1; wb_wb_en = 1'b1; wb_rd = 4'd7; wb_data = 32'h77;
          push_exp(32'h77, 32'hdead, 1'b1, 32'h0);
        end
        1: begin
          ld_pending(4'd6);
          set_ex(2'b11, 4'd6, 4'd7, 32'hdead, 32'h0);
          push_exp(32'h77, 32'hdead, 1'b1, 32'h0);
        end
        2: begin
          rst = 1'b1;
          ld_pending(4'd6);
          set_ex(2'b11, 4'd6, 4'd7, 32'hdead, 32'h0);
          ex_valid = 1'b0;
          push_exp(32'h77, 32'hdead, 1'b0, 32'h0);
        end
        default: begin
          exp_cnt = 0;
          set_ex(2'b11, 4'd6, 4'd7, 32'h4, 32'h3);
          push_exp(32'h3, 32'h4, 1'b0, 32'h0);
        end
      endcase
      @(negedge clk);
      e = sb.pop_front(); n_chk++;
      if ({ex_opnd[31:0], ex_opnd[63:32], ex_stall, mem_store_data_o, lu_stall_cnt} !==
          {e.op0, e.op1, e.stall, e.sdata, e.cnt}) begin
        n_fail++;
        $display("FAIL reset_mid_stall c%0d: got op0=%h op1=%h stall=%b sd=%h cnt=%0d want op0=%h op1=%h stall=%b sd=%h cnt=%0d",
                 c, ex_opnd[31:0], ex_opnd[63:32], ex_stall, mem_store_data_o, lu_stall_cnt,
                 e.op0, e.op1, e.stall, e.sdata, e.cnt);
      end
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_back_to_back();
    test_load_use();
    test_hold();
    test_load_store();
    test_x0_flush();
    test_reset_mid_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
